// File: rtl/threshold_trigger.sv
// Signed-sample trigger discriminator: minimum-run qualification, hysteresis
// release and post-release hold-off, producing a registered gate, edge pulse and trigger count.
module threshold_trigger #(
  parameter int SAMPLE_WIDTH   = 14,
  parameter int CNT_WIDTH      = 5,
  parameter int TRIG_CNT_WIDTH = 16
) (
  input  logic                             CLK,
  input  logic                             RESETN,
  input  logic                             ENABLE,
  input  logic                             S_VALID,
  input  logic signed [SAMPLE_WIDTH-1:0]   S_DATA,
  input  logic signed [SAMPLE_WIDTH-1:0]   TH_HIGH,
  input  logic signed [SAMPLE_WIDTH-1:0]   TH_LOW,
  input  logic        [CNT_WIDTH-1:0]      MIN_OVER,
  input  logic        [CNT_WIDTH-1:0]      HOLDOFF,
  output logic                             SIG_OUT,
  output logic                             RISE,
  output logic        [TRIG_CNT_WIDTH-1:0] TRIG_COUNT
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMING = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0]      CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH:0]        RUN_ONE  = (CNT_WIDTH + 1)'(1);
  localparam logic [TRIG_CNT_WIDTH-1:0] TRIG_ONE = TRIG_CNT_WIDTH'(1);

  function automatic logic [CNT_WIDTH-1:0] sat_inc_cnt(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  function automatic logic [TRIG_CNT_WIDTH-1:0] sat_inc_trig(input logic [TRIG_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + TRIG_ONE;
  endfunction

  state_t                    state, state_n;
  logic [CNT_WIDTH-1:0]      cnt, cnt_n;
  logic                      fire;
  logic                      sig_p1, rise_p1;
  logic [TRIG_CNT_WIDTH-1:0] trig_cnt_p1;

  // Stage 0: combinational sample qualification against live thresholds
  logic                      vld_p0, over_p0, under_p0;
  logic [CNT_WIDTH:0]        run_nxt_p0;

  assign vld_p0     = S_VALID;
  assign over_p0    = (S_DATA >= TH_HIGH);
  assign under_p0   = (S_DATA < TH_LOW);
  assign run_nxt_p0 = {1'b0, cnt} + RUN_ONE;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    fire    = 1'b0;
    if (!ENABLE) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (vld_p0 && over_p0) begin
            if (MIN_OVER <= CNT_ONE) begin
              state_n = ST_ACTIVE;
              cnt_n   = '0;
              fire    = 1'b1;
            end else begin
              state_n = ST_ARMING;
              cnt_n   = CNT_ONE;
            end
          end
        end
        ST_ARMING: begin
          if (vld_p0) begin
            if (over_p0) begin
              // >= rather than == so a lowered MIN_OVER mid-run still asserts
              if (run_nxt_p0 >= {1'b0, MIN_OVER}) begin
                state_n = ST_ACTIVE;
                cnt_n   = '0;
                fire    = 1'b1;
              end else begin
                cnt_n = sat_inc_cnt(cnt);
              end
            end else begin
              state_n = ST_IDLE;
              cnt_n   = '0;
            end
          end
        end
        ST_ACTIVE: begin
          if (vld_p0 && under_p0) begin
            if (HOLDOFF == '0) begin
              state_n = ST_IDLE;
              cnt_n   = '0;
            end else begin
              state_n = ST_HOLD;
              cnt_n   = CNT_ONE;
            end
          end
        end
        ST_HOLD: begin
          // Counts clock cycles, not samples; the release edge counted as 1
          if (cnt >= HOLDOFF) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = sat_inc_cnt(cnt);
          end
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Stage 1: registered state, gate, edge pulse and trigger count
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      sig_p1      <= 1'b0;
      rise_p1     <= 1'b0;
      trig_cnt_p1 <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sig_p1  <= (state_n == ST_ACTIVE);
      rise_p1 <= fire;
      if (fire) begin
        trig_cnt_p1 <= sat_inc_trig(trig_cnt_p1);
      end
    end
  end

  assign SIG_OUT    = sig_p1;
  assign RISE       = rise_p1;
  assign TRIG_COUNT = trig_cnt_p1;

endmodule
